cia_timer_ctrl: RTL



---
 rtl/cia_timer_ctrl_if.sv | 33 +++
 rtl/cia_timer_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/cia_timer_ctrl_if.sv
// Timer-control bundle type and the bus interface between the CIA top level and cia_timer_ctrl.
`timescale 1ns/1ps

package cia;
    typedef struct packed {
        logic start;
        logic count;
        logic force_load;
        logic outmode;
    } tctrl_t;
endpackage

interface cia_timer_ctrl_if;
    logic         phi2_dn;
    logic         cr_w;
    logic [7:0]   data;
    logic         t_int;
    logic         ta_int;
    logic         cnt;
    cia::tctrl_t  ctrl;
    logic         pbon;
    logic [7:0]   cr_rd;

    modport master (
        output phi2_dn, cr_w, data, t_int, ta_int, cnt,
        input  ctrl, pbon, cr_rd
    );

    modport slave (
        input  phi2_dn, cr_w, data, t_int, ta_int, cnt,
        output ctrl, pbon, cr_rd
    );
endinterface

// File: rtl/cia_timer_ctrl.sv
// Control-register sequencer for one CIA interval timer (CRA or CRB layout via TIMER_B).
// Define CIA_COUNT_DELAY_EN to insert the two-stage PHI2 count-delay pipeline of the 6526.
`timescale 1ns/1ps

module cia_timer_ctrl #(
    parameter bit TIMER_B = 1'b0
) (
    input  logic            clk,
    input  logic            res_n,
    cia_timer_ctrl_if.slave bus
);

    logic       start_q, start_d;
    logic       pbon_q, pbon_d;
    logic       outmode_q, outmode_d;
    logic       runmode_q, runmode_d;
    logic [2:0] upper_q, upper_d;
    logic       fload_q, fload_d;
    logic       cnt_p0_q, cnt_p1_q;
    logic       cnt_rise;
    logic       raw_evt;
    logic       oneshot_stop;
    logic       count_w;

    // Count-source selection; CRA only looks at INMODE bit 5.
    function automatic logic count_event(input logic [1:0] inmode,
                                         input logic       rise,
                                         input logic       cnt_hi,
                                         input logic       ta);
        logic ev;
        if (!TIMER_B) begin
            ev = inmode[0] ? rise : 1'b1;
        end else begin
            case (inmode)
                2'b00:   ev = 1'b1;
                2'b01:   ev = rise;
                2'b10:   ev = ta;
                default: ev = ta & cnt_hi;
            endcase
        end
        return ev;
    endfunction

    assign cnt_rise     = cnt_p0_q & ~cnt_p1_q;
    assign raw_evt      = start_q & count_event(upper_q[1:0], cnt_rise, cnt_p1_q, bus.ta_int);
    assign oneshot_stop = !bus.cr_w && bus.t_int && runmode_q;

    always_comb begin
        start_d   = start_q;
        pbon_d    = pbon_q;
        outmode_d = outmode_q;
        runmode_d = runmode_q;
        upper_d   = upper_q;
        fload_d   = 1'b0;
        if (bus.cr_w) begin
            start_d   = bus.data[0];
            pbon_d    = bus.data[1];
            outmode_d = bus.data[2];
            runmode_d = bus.data[3];
            upper_d   = bus.data[7:5];
            fload_d   = bus.data[4];
        end else if (oneshot_stop) begin
            start_d   = 1'b0;
        end
    end

    // Stage boundary: control register and CNT synchronizer, advanced once per PHI2 cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            start_q   <= 1'b0;
            pbon_q    <= 1'b0;
            outmode_q <= 1'b0;
            runmode_q <= 1'b0;
            upper_q   <= 3'b000;
            fload_q   <= 1'b0;
            cnt_p0_q  <= 1'b1;
            cnt_p1_q  <= 1'b1;
        end else if (bus.phi2_dn) begin
            start_q   <= start_d;
            pbon_q    <= pbon_d;
            outmode_q <= outmode_d;
            runmode_q <= runmode_d;
            upper_q   <= upper_d;
            fload_q   <= fload_d;
            cnt_p0_q  <= bus.cnt;
            cnt_p1_q  <= cnt_p0_q;
        end
    end

`ifdef CIA_COUNT_DELAY_EN
    logic evt_p1_q, evt_p2_q;

    // Stage boundary: two-deep count-delay pipeline, flushed by a one-shot stop.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            evt_p1_q <= 1'b0;
            evt_p2_q <= 1'b0;
        end else if (bus.phi2_dn) begin
            if (oneshot_stop) begin
                evt_p1_q <= 1'b0;
                evt_p2_q <= 1'b0;
            end else begin
                evt_p1_q <= raw_evt;
                evt_p2_q <= evt_p1_q;
            end
        end
    end

    assign count_w = evt_p2_q;
`else
    assign count_w = raw_evt;
`endif

    // Field order matches tctrl_t: start, count, force_load, outmode.
    assign bus.ctrl  = {start_q, count_w, fload_q, outmode_q};
    assign bus.pbon  = pbon_q;
    assign bus.cr_rd = {upper_q, 1'b0, runmode_q, outmode_q, pbon_q, start_q};

endmodule
